// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-port controller.
//   - FSM state encoding (idle, fetch, load, store, response)
//   - word / reply-line widths and the reset value used for data words
//   - select_word(): picks the addressed 32-bit word out of a 64-bit reply line
package mem_ctrl_pkg;

  localparam int INST_W = 32;
  localparam int REP_W  = 64;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {
    MC_IDLE  = 3'd0,
    MC_FETCH = 3'd1,
    MC_LOAD  = 3'd2,
    MC_STORE = 3'd3,
    MC_RESP  = 3'd4
  } mc_state_e;

  // A reply line is {word at line+4, word at line+0}; address bit 2 selects the half.
  function automatic logic [INST_W-1:0] select_word(input logic [REP_W-1:0] line,
                                                    input logic             upper);
    return upper ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Two-way round-robin grant for the shared memory port.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   if_req     fetch request pending
//   mem_req    load/store request pending
//   update     a grant is being taken this cycle; remember who won
//   grant_mem  1 = MEM stage wins, 0 = IF stage wins (meaningful when a request is pending)
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic mem_req,
  input  logic update,
  output logic grant_mem
);

  logic last_mem;

  // MEM is preferred, except right after a MEM grant when IF is also waiting.
  always_comb begin
    grant_mem = mem_req & ~(if_req & last_mem);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_mem <= 1'b0;
    end else if (update) begin
      last_mem <= grant_mem;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// CPU-side initiator for the memory-simulator request/reply interface.
// Arbitrates IF fetches and MEM loads/stores onto one memory port, latches the
// winner's operands, drives the request, extracts the addressed 32-bit word from
// the 64-bit reply and acks the requesting stage. One transaction at a time.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_req_i/if_addr_i               fetch request and address
//   if_ack_o/if_inst_o               fetch done pulse and fetched word (held)
//   mem_req_i/mem_we_i/mem_addr_i    load/store request, direction, address
//   mem_wdata_i/mem_mask_i           store data and byte mask
//   mem_ack_o/mem_rdata_o            load/store done pulse and loaded word (held)
//   stall_req_o                      a stage is waiting for its ack
//   err_o                            sticky read-timeout flag
//   if_ms_req_o/if_addr_o            fetch request to memory and latched address
//   mem_ms_req_o/mem_addr_o          load request to memory and latched address
//   ms_write_o/ms_write_data_o/ms_write_mask_o   single-cycle store strobe and operands
//   if_ms_rep_i/if_ms_rep_data_i     fetch reply valid and 64-bit line
//   mem_ms_rep_i/mem_ms_rep_data_i   load reply valid and 64-bit line
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_ack_o,
  output logic [INST_W-1:0] if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [3:0]        mem_mask_i,
  output logic              mem_ack_o,
  output logic [INST_W-1:0] mem_rdata_o,
  output logic              stall_req_o,
  output logic              err_o,
  output logic              if_ms_req_o,
  output logic [31:0]       if_addr_o,
  output logic              mem_ms_req_o,
  output logic [31:0]       mem_addr_o,
  output logic              ms_write_o,
  output logic [31:0]       ms_write_data_o,
  output logic [3:0]        ms_write_mask_o,
  input  logic              if_ms_rep_i,
  input  logic [REP_W-1:0]  if_ms_rep_data_i,
  input  logic              mem_ms_rep_i,
  input  logic [REP_W-1:0]  mem_ms_rep_data_i
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mc_state_e        state;
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_mem;
  logic             any_req;
  logic             arb_update;

  assign any_req    = if_req_i | mem_req_i;
  assign arb_update = (state == MC_IDLE) & any_req;

  mem_ctrl_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req_i),
    .mem_req   (mem_req_i),
    .update    (arb_update),
    .grant_mem (grant_mem)
  );

  assign stall_req_o = any_req & ~(if_ack_o | mem_ack_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= MC_IDLE;
      wait_cnt        <= '0;
      if_ack_o        <= 1'b0;
      if_inst_o       <= ZERO_WORD;
      mem_ack_o       <= 1'b0;
      mem_rdata_o     <= ZERO_WORD;
      err_o           <= 1'b0;
      if_ms_req_o     <= 1'b0;
      if_addr_o       <= ZERO_WORD;
      mem_ms_req_o    <= 1'b0;
      mem_addr_o      <= ZERO_WORD;
      ms_write_o      <= 1'b0;
      ms_write_data_o <= ZERO_WORD;
      ms_write_mask_o <= 4'b0000;
    end else begin
      case (state)
        // Grant the port and latch the winner's operands.
        MC_IDLE: begin
          wait_cnt <= '0;
          if (any_req) begin
            if (grant_mem) begin
              mem_addr_o <= mem_addr_i;
              if (mem_we_i) begin
                ms_write_data_o <= mem_wdata_i;
                ms_write_mask_o <= mem_mask_i;
                ms_write_o      <= 1'b1;
                state           <= MC_STORE;
              end else begin
                mem_ms_req_o <= 1'b1;
                state        <= MC_LOAD;
              end
            end else begin
              if_addr_o   <= if_addr_i;
              if_ms_req_o <= 1'b1;
              state       <= MC_FETCH;
            end
          end
        end

        // Wait for the fetch reply, or abandon after the timeout.
        MC_FETCH: begin
          if (if_ms_rep_i) begin
            if_inst_o   <= select_word(if_ms_rep_data_i, if_addr_o[2]);
            if_ack_o    <= 1'b1;
            if_ms_req_o <= 1'b0;
            state       <= MC_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            err_o       <= 1'b1;
            if_ms_req_o <= 1'b0;
            state       <= MC_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        // Wait for the load reply, or abandon after the timeout.
        MC_LOAD: begin
          if (mem_ms_rep_i) begin
            mem_rdata_o  <= select_word(mem_ms_rep_data_i, mem_addr_o[2]);
            mem_ack_o    <= 1'b1;
            mem_ms_req_o <= 1'b0;
            state        <= MC_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            err_o        <= 1'b1;
            mem_ms_req_o <= 1'b0;
            state        <= MC_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        // Stores are posted: one strobe cycle, no reply.
        MC_STORE: begin
          ms_write_o <= 1'b0;
          mem_ack_o  <= 1'b1;
          state      <= MC_RESP;
        end

        // Ack was raised on entry; drop it after one cycle.
        MC_RESP: begin
          if_ack_o  <= 1'b0;
          mem_ack_o <= 1'b0;
          state     <= MC_IDLE;
        end

        default: begin
          state <= MC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_inst_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_mask_i;
  logic        mem_ack_o;
  logic [31:0] mem_rdata_o;
  logic        stall_req_o;
  logic        err_o;
  logic        if_ms_req_o;
  logic [31:0] if_addr_o;
  logic        mem_ms_req_o;
  logic [31:0] mem_addr_o;
  logic        ms_write_o;
  logic [31:0] ms_write_data_o;
  logic [3:0]  ms_write_mask_o;
  logic        if_ms_rep_i;
  logic [63:0] if_ms_rep_data_i;
  logic        mem_ms_rep_i;
  logic [63:0] mem_ms_rep_data_i;

  int n_checks = 0;
  int n_pass   = 0;

  mem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_req_i          (if_req_i),
    .if_addr_i         (if_addr_i),
    .if_ack_o          (if_ack_o),
    .if_inst_o         (if_inst_o),
    .mem_req_i         (mem_req_i),
    .mem_we_i          (mem_we_i),
    .mem_addr_i        (mem_addr_i),
    .mem_wdata_i       (mem_wdata_i),
    .mem_mask_i        (mem_mask_i),
    .mem_ack_o         (mem_ack_o),
    .mem_rdata_o       (mem_rdata_o),
    .stall_req_o       (stall_req_o),
    .err_o             (err_o),
    .if_ms_req_o       (if_ms_req_o),
    .if_addr_o         (if_addr_o),
    .mem_ms_req_o      (mem_ms_req_o),
    .mem_addr_o        (mem_addr_o),
    .ms_write_o        (ms_write_o),
    .ms_write_data_o   (ms_write_data_o),
    .ms_write_mask_o   (ms_write_mask_o),
    .if_ms_rep_i       (if_ms_rep_i),
    .if_ms_rep_data_i  (if_ms_rep_data_i),
    .mem_ms_rep_i      (mem_ms_rep_i),
    .mem_ms_rep_data_i (mem_ms_rep_data_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    if_req_i  = 1'b0;
    mem_req_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    if_addr_i         = '0;
    mem_we_i          = 1'b0;
    mem_addr_i        = '0;
    mem_wdata_i       = '0;
    mem_mask_i        = '0;
    if_ms_rep_i       = 1'b0;
    if_ms_rep_data_i  = '0;
    mem_ms_rep_i      = 1'b0;
    mem_ms_rep_data_i = '0;
    do_reset();

    // Reset state
    check("rst_ctrl", 64'({if_ack_o, mem_ack_o, err_o, if_ms_req_o, mem_ms_req_o, ms_write_o, stall_req_o}), 64'h0);
    check("rst_words", 64'({if_inst_o, mem_rdata_o}), 64'h0);
    check("rst_addrs", 64'({if_addr_o, mem_addr_o}), 64'h0);

    // Fetch 0xC, same-cycle reply: upper word selected
    if_req_i         = 1'b1;
    if_addr_i        = 32'h0000_000C;
    if_ms_rep_i      = 1'b1;
    if_ms_rep_data_i = 64'hAAAA_BBBB_1111_2222;
    tick();
    check("fetch_req", 64'({if_ms_req_o, mem_ms_req_o, if_ack_o, stall_req_o}), 64'b1001);
    check("fetch_addr", 64'(if_addr_o), 64'h0000_000C);
    tick();
    check("fetch_ack", 64'({if_ms_req_o, if_ack_o, stall_req_o}), 64'b010);
    check("fetch_inst", 64'(if_inst_o), 64'hAAAA_BBBB);
    if_req_i    = 1'b0;
    if_ms_rep_i = 1'b0;
    tick();
    check("fetch_ack_drop", 64'(if_ack_o), 64'h0);

    // Load 0x8 with a delayed reply: lower word selected, stall held until ack
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h0000_0008;
    tick();
    check("load_req1", 64'({mem_ms_req_o, if_ms_req_o, stall_req_o, mem_ack_o}), 64'b1010);
    check("load_addr", 64'(mem_addr_o), 64'h0000_0008);
    tick();
    check("load_req2", 64'({mem_ms_req_o, stall_req_o}), 64'b11);
    mem_ms_rep_i      = 1'b1;
    mem_ms_rep_data_i = 64'hAAAA_BBBB_1111_2222;
    tick();
    check("load_ack", 64'({mem_ms_req_o, mem_ack_o, stall_req_o}), 64'b010);
    check("load_data", 64'(mem_rdata_o), 64'h1111_2222);
    mem_req_i    = 1'b0;
    mem_ms_rep_i = 1'b0;
    tick();

    // Store 0x104 / 0x41 / mask 0001
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_addr_i  = 32'h0000_0104;
    mem_wdata_i = 32'h0000_0041;
    mem_mask_i  = 4'b0001;
    tick();
    check("store_strobe", 64'({ms_write_o, mem_ms_req_o, if_ms_req_o, mem_ack_o}), 64'b1000);
    check("store_ops", {mem_addr_o, ms_write_data_o}, 64'h0000_0104_0000_0041);
    check("store_mask", 64'(ms_write_mask_o), 64'h1);
    mem_addr_i  = 32'hDEAD_BEEF;
    mem_wdata_i = 32'h1234_5678;
    tick();
    check("store_ack", 64'({ms_write_o, mem_ms_req_o, mem_ack_o}), 64'b001);
    check("store_hold", {mem_addr_o, ms_write_data_o}, 64'h0000_0104_0000_0041);
    check("store_rdata_kept", 64'(mem_rdata_o), 64'h1111_2222);
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
    tick();
    check("store_ack_drop", 64'(mem_ack_o), 64'h0);

    // Both stages held for four accesses: MEM, IF, MEM, IF
    do_reset();
    if_req_i          = 1'b1;
    if_addr_i         = 32'h0000_0020;
    mem_req_i         = 1'b1;
    mem_we_i          = 1'b0;
    mem_addr_i        = 32'h0000_0034;
    if_ms_rep_i       = 1'b1;
    if_ms_rep_data_i  = 64'h1234_5678_9ABC_DEF0;
    mem_ms_rep_i      = 1'b1;
    mem_ms_rep_data_i = 64'hCAFE_F00D_0BAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      logic exp_mem;
      exp_mem = (k % 2 == 0);
      tick();
      check($sformatf("arb_grant%0d", k), 64'({if_ms_req_o, mem_ms_req_o, ms_write_o}),
            exp_mem ? 64'b010 : 64'b100);
      tick();
      check($sformatf("arb_ack%0d", k), 64'({if_ack_o, mem_ack_o}), exp_mem ? 64'b01 : 64'b10);
      if (exp_mem) check($sformatf("arb_data%0d", k), 64'(mem_rdata_o), 64'hCAFE_F00D);
      else         check($sformatf("arb_data%0d", k), 64'(if_inst_o), 64'h9ABC_DEF0);
      tick();
    end
    if_req_i     = 1'b0;
    mem_req_i    = 1'b0;
    if_ms_rep_i  = 1'b0;
    mem_ms_rep_i = 1'b0;
    tick();

    // Load timeout: no reply ever; abort after 16 cycles in LOAD
    begin
      int acks;
      acks       = 0;
      mem_req_i  = 1'b1;
      mem_we_i   = 1'b0;
      mem_addr_i = 32'h0000_0040;
      for (int c = 0; c < 16; c++) begin
        tick();
        if (mem_ack_o | if_ack_o) acks++;
      end
      check("tmo_pending", 64'({err_o, mem_ms_req_o}), 64'b01);
      tick();
      if (mem_ack_o | if_ack_o) acks++;
      check("tmo_abort", 64'({err_o, mem_ms_req_o, mem_ack_o}), 64'b100);
      mem_req_i = 1'b0;
      tick();
      if (mem_ack_o | if_ack_o) acks++;
      check("tmo_no_ack", 64'(acks), 64'h0);
    end

    // Fetch still served after the timeout; err stays sticky
    if_req_i         = 1'b1;
    if_addr_i        = 32'h0000_0004;
    if_ms_rep_i      = 1'b1;
    if_ms_rep_data_i = 64'h5555_6666_7777_8888;
    tick();
    check("post_tmo_req", 64'(if_ms_req_o), 64'h1);
    tick();
    check("post_tmo_ack", 64'({if_ack_o, err_o}), 64'b11);
    check("post_tmo_inst", 64'(if_inst_o), 64'h5555_6666);
    if_req_i    = 1'b0;
    if_ms_rep_i = 1'b0;
    tick();

    // Reset in the middle of a load: everything cleared, late reply ignored
    mem_req_i    = 1'b1;
    mem_addr_i   = 32'h0000_0050;
    mem_ms_rep_i = 1'b0;
    tick();
    check("rst_mid_req", 64'(mem_ms_req_o), 64'h1);
    rst       = 1'b1;
    mem_req_i = 1'b0;
    tick();
    check("rst_mid_ctrl", 64'({if_ack_o, mem_ack_o, err_o, if_ms_req_o, mem_ms_req_o, ms_write_o, stall_req_o}), 64'h0);
    check("rst_mid_words", {if_inst_o, mem_rdata_o}, 64'h0);
    check("rst_mid_addrs", {if_addr_o, mem_addr_o}, 64'h0);
    rst               = 1'b0;
    mem_ms_rep_i      = 1'b1;
    mem_ms_rep_data_i = 64'hFFFF_EEEE_DDDD_CCCC;
    begin
      int late_acks;
      late_acks = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (mem_ack_o) late_acks++;
      end
      check("rst_late_ack", 64'(late_acks), 64'h0);
      check("rst_late_data", 64'(mem_rdata_o), 64'h0);
    end
    mem_ms_rep_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
